// File: rtl/multicycle_alu.sv
// multicycle_alu
//   Execute-stage ALU. Logic ops, add/sub and signed set-less-than finish in
//   one cycle. Shifts move one bit per cycle, and multiply is shift-and-add
//   with one multiplier bit per cycle. Busy stalls the pipeline while one of
//   these iterative ops runs.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   Start      request; sampled only while Busy = 0
//   Flush      abort an in-flight iterative op, or block a Start in IDLE
//   Operation  4-bit op code from the ALU control decoder
//   SrcA/SrcB  operands, captured when the request is accepted
//   ALUResult  registered result, held until the next completion
//   Zero       ALUResult == 0
//   Busy       an iterative op is in flight
//   Done       one-cycle pulse; ALUResult was written on the previous edge
module multicycle_alu #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic                  Flush,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero,
    output logic                  Busy,
    output logic                  Done
);

    localparam int unsigned SW = $clog2(DATA_WIDTH);
    // One extra bit so the counter can hold DATA_WIDTH for multiply.
    localparam int unsigned CW = SW + 1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_XOR = 4'b0011,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_SLL = 4'b1000,
        OP_SRL = 4'b1001,
        OP_SRA = 4'b1010,
        OP_MUL = 4'b1011
    } op_t;

    typedef enum logic [1:0] {
        IT_SLL,
        IT_SRL,
        IT_SRA,
        IT_MUL
    } iter_t;

    // Registered state
    state_t                state, state_n;
    iter_t                 kind, kind_n;
    logic [DATA_WIDTH-1:0] acc, acc_n;
    logic [DATA_WIDTH-1:0] mcand, mcand_n;
    logic [DATA_WIDTH-1:0] mplier, mplier_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [DATA_WIDTH-1:0] result_n;
    logic                  done_n;

    // Combinational helpers
    logic [DATA_WIDTH-1:0] single_res;
    logic [DATA_WIDTH-1:0] step_val;
    logic [SW-1:0]         shamt;
    logic                  is_shift;
    logic                  lt;
    iter_t                 shift_kind;

    assign shamt = SrcB[SW-1:0];
    assign Busy  = (state == ST_RUN);
    assign Zero  = (ALUResult == '0);

    // Result for ops that finish on the accepting edge. A shift only takes
    // this path when its amount is zero, so its result is SrcA unchanged.
    always_comb begin
        single_res = '0;
        lt         = ($signed(SrcA) < $signed(SrcB));
        case (Operation)
            OP_AND:                 single_res = SrcA & SrcB;
            OP_OR:                  single_res = SrcA | SrcB;
            OP_XOR:                 single_res = SrcA ^ SrcB;
            OP_ADD:                 single_res = SrcA + SrcB;
            OP_SUB:                 single_res = SrcA - SrcB;
            OP_SLT:                 single_res = {{(DATA_WIDTH-1){1'b0}}, lt};
            OP_SLL, OP_SRL, OP_SRA: single_res = SrcA;
            default:                single_res = '0;
        endcase
    end

    // Classify shifts for the iterative path
    always_comb begin
        is_shift   = 1'b0;
        shift_kind = IT_SLL;
        case (Operation)
            OP_SLL: begin
                is_shift   = 1'b1;
                shift_kind = IT_SLL;
            end
            OP_SRL: begin
                is_shift   = 1'b1;
                shift_kind = IT_SRL;
            end
            OP_SRA: begin
                is_shift   = 1'b1;
                shift_kind = IT_SRA;
            end
            default: begin
                is_shift   = 1'b0;
                shift_kind = IT_SLL;
            end
        endcase
    end

    // One iteration of the op in flight
    always_comb begin
        step_val = acc;
        case (kind)
            IT_SLL:  step_val = acc << 1;
            IT_SRL:  step_val = acc >> 1;
            IT_SRA:  step_val = {acc[DATA_WIDTH-1], acc[DATA_WIDTH-1:1]};
            IT_MUL:  step_val = acc + (mplier[0] ? mcand : '0);
            default: step_val = acc;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_n  = state;
        kind_n   = kind;
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        cnt_n    = cnt;
        result_n = ALUResult;
        done_n   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (Start && !Flush) begin
                    if (Operation == OP_MUL) begin
                        kind_n   = IT_MUL;
                        acc_n    = '0;
                        mcand_n  = SrcA;
                        mplier_n = SrcB;
                        cnt_n    = CW'(DATA_WIDTH);
                        state_n  = ST_RUN;
                    end else if (is_shift && (shamt != '0)) begin
                        kind_n  = shift_kind;
                        acc_n   = SrcA;
                        cnt_n   = {1'b0, shamt};
                        state_n = ST_RUN;
                    end else begin
                        result_n = single_res;
                        done_n   = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (Flush) begin
                    state_n = ST_IDLE;
                end else begin
                    acc_n = step_val;
                    cnt_n = cnt - CW'(1);
                    if (kind == IT_MUL) begin
                        mcand_n  = mcand << 1;
                        mplier_n = mplier >> 1;
                    end
                    // The last step's value goes straight to the result so
                    // Done lines up with the edge that leaves RUN.
                    if (cnt == CW'(1)) begin
                        result_n = step_val;
                        done_n   = 1'b1;
                        state_n  = ST_IDLE;
                    end
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            kind      <= IT_SLL;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            ALUResult <= '0;
            Done      <= 1'b0;
        end else begin
            state     <= state_n;
            kind      <= kind_n;
            acc       <= acc_n;
            mcand     <= mcand_n;
            mplier    <= mplier_n;
            cnt       <= cnt_n;
            ALUResult <= result_n;
            Done      <= done_n;
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu. Expected results are computed by a small
// reference function and queued when a request is driven; a monitor pops and
// compares on every Done pulse. Timing checks live in the stimulus block.
module tb_multicycle_alu;

    logic        clk;
    logic        reset;
    logic        Start;
    logic        Flush;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Busy;
    logic        Done;

    int unsigned checks;
    int unsigned errors;
    int unsigned done_cnt;
    logic [31:0] exp_q[$];

    multicycle_alu #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Flush     (Flush),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .ALUResult (ALUResult),
        .Zero      (Zero),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] prod;
        int unsigned k;
        k    = int'(b[4:0]);
        prod = {32'd0, a} * {32'd0, b};
        case (op)
            4'b0000: ref_alu = a & b;
            4'b0001: ref_alu = a | b;
            4'b0011: ref_alu = a ^ b;
            4'b0010: ref_alu = a + b;
            4'b0110: ref_alu = a - b;
            4'b0111: ref_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: ref_alu = a << k;
            4'b1001: ref_alu = a >> k;
            4'b1010: ref_alu = 32'($signed(a) >>> k);
            4'b1011: ref_alu = prod[31:0];
            default: ref_alu = 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request for the next edge; queue its result if it should complete.
    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit expect_done);
        Start     = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        if (expect_done) exp_q.push_back(ref_alu(op, a, b));
    endtask

    task automatic wait_done(output int unsigned lat);
        lat = 1;
        while (Done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && Done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(Done), 64'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("result", 64'(ALUResult), 64'(e));
                chk("zero", 64'(Zero), 64'(e == 32'd0));
            end
        end
    end

    initial begin
        int unsigned lat;
        int unsigned snap;
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        reset     = 1'b1;
        Start     = 1'b0;
        Flush     = 1'b0;
        Operation = 4'b0000;
        SrcA      = '0;
        SrcB      = '0;

        // Reset
        tick();
        tick();
        chk("rst_result", 64'(ALUResult), 64'd0);
        chk("rst_zero", 64'(Zero), 64'd1);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        reset = 1'b0;

        // First op: ADD 3+4, one-cycle latency
        drive(4'b0010, 32'd3, 32'd4, 1'b1);
        tick();
        Start = 1'b0;
        chk("add_done", 64'(Done), 64'd1);
        chk("add_val", 64'(ALUResult), 64'd7);
        chk("add_zero", 64'(Zero), 64'd0);
        tick();
        chk("add_done_drop", 64'(Done), 64'd0);

        // Back-to-back single-cycle ops
        drive(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b1);
        tick();
        chk("b2b_done0", 64'(Done), 64'd1);
        drive(4'b0110, 32'd5, 32'd7, 1'b1);
        tick();
        chk("b2b_done1", 64'(Done), 64'd1);
        chk("b2b_sub", 64'(ALUResult), 64'hFFFF_FFFE);
        drive(4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b1);
        tick();
        chk("b2b_done2", 64'(Done), 64'd1);
        chk("b2b_slt1", 64'(ALUResult), 64'd1);
        drive(4'b0111, 32'd1, 32'hFFFF_FFFF, 1'b1);
        tick();
        Start = 1'b0;
        chk("b2b_done3", 64'(Done), 64'd1);
        chk("b2b_slt0", 64'(ALUResult), 64'd0);
        drive(4'b0000, 32'hF0F0_1234, 32'hFF00_FF00, 1'b1);
        tick();
        drive(4'b0001, 32'h0000_00F0, 32'h0F00_000F, 1'b1);
        tick();
        drive(4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1);
        tick();
        drive(4'b0100, 32'h1234_5678, 32'd1, 1'b1);
        tick();
        drive(4'b1100, 32'h1234_5678, 32'd1, 1'b1);
        tick();
        Start = 1'b0;
        tick();
        chk("b2b_idle", 64'(Done), 64'd0);

        // SRA k=4 (upper SrcB bits ignored), ADD during Busy is ignored
        drive(4'b1010, 32'h8000_0000, 32'h24, 1'b1);
        tick();
        Start     = 1'b1;
        Operation = 4'b0010;
        SrcA      = 32'd9;
        SrcB      = 32'd9;
        for (int i = 0; i < 4; i++) begin
            chk("sra_busy", 64'(Busy), 64'd1);
            chk("sra_nodone", 64'(Done), 64'd0);
            tick();
        end
        Start = 1'b0;
        chk("sra_done", 64'(Done), 64'd1);
        chk("sra_busy_fall", 64'(Busy), 64'd0);
        chk("sra_val", 64'(ALUResult), 64'hF800_0000);
        tick();
        chk("busy_start_ignored", 64'(Done), 64'd0);
        chk("sra_hold", 64'(ALUResult), 64'hF800_0000);

        // SLL with k = 0 is single-cycle
        drive(4'b1000, 32'h1234_5678, 32'h20, 1'b1);
        tick();
        Start = 1'b0;
        chk("sll0_done", 64'(Done), 64'd1);
        chk("sll0_busy", 64'(Busy), 64'd0);
        chk("sll0_val", 64'(ALUResult), 64'h1234_5678);

        // Short and maximum-length shifts
        drive(4'b1001, 32'h8000_0000, 32'd1, 1'b1);
        tick();
        Start = 1'b0;
        wait_done(lat);
        chk("srl1_lat", 64'(lat), 64'd2);
        drive(4'b1000, 32'd3, 32'd31, 1'b1);
        tick();
        Start = 1'b0;
        wait_done(lat);
        chk("sll31_lat", 64'(lat), 64'd32);

        // MUL, with the next MUL accepted in the Done cycle
        drive(4'b1011, 32'h0001_0003, 32'd5, 1'b1);
        tick();
        Start = 1'b0;
        wait_done(lat);
        chk("mul_lat", 64'(lat), 64'd33);
        chk("mul_val", 64'(ALUResult), 64'h0005_000F);
        drive(4'b1011, 32'hFFFF_FFFD, 32'd7, 1'b1);
        tick();
        Start = 1'b0;
        wait_done(lat);
        chk("mul2_lat", 64'(lat), 64'd33);
        chk("mul2_val", 64'(ALUResult), 64'hFFFF_FFEB);
        drive(4'b0010, 32'd1, 32'd1, 1'b1);
        tick();
        Start = 1'b0;
        chk("nobubble_done", 64'(Done), 64'd1);
        chk("nobubble_val", 64'(ALUResult), 64'd2);

        // Flush at the 10th RUN cycle of a MUL
        drive(4'b1011, 32'h1234, 32'h5678, 1'b0);
        tick();
        Start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("flush_pre_busy", 64'(Busy), 64'd1);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("flush_busy", 64'(Busy), 64'd0);
        chk("flush_done", 64'(Done), 64'd0);
        chk("flush_hold", 64'(ALUResult), 64'd2);
        snap = done_cnt;
        for (int i = 0; i < 40; i++) tick();
        chk("flush_no_done", 64'(done_cnt), 64'(snap));

        // Flush with Start in IDLE blocks acceptance
        drive(4'b0010, 32'd5, 32'd5, 1'b0);
        Flush = 1'b1;
        tick();
        Start = 1'b0;
        Flush = 1'b0;
        chk("flush_idle_done", 64'(Done), 64'd0);
        chk("flush_idle_val", 64'(ALUResult), 64'd2);
        drive(4'b1011, 32'd5, 32'd5, 1'b0);
        Flush = 1'b1;
        tick();
        Start = 1'b0;
        Flush = 1'b0;
        chk("flush_idle_busy", 64'(Busy), 64'd0);

        // Reset in the middle of an SRL k=20
        drive(4'b1001, 32'hFFFF_FFFF, 32'd20, 1'b0);
        tick();
        Start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_mid_busy_pre", 64'(Busy), 64'd1);
        snap  = done_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", 64'(Busy), 64'd0);
        chk("rst_mid_val", 64'(ALUResult), 64'd0);
        chk("rst_mid_zero", 64'(Zero), 64'd1);
        chk("rst_mid_done", 64'(Done), 64'd0);
        for (int i = 0; i < 30; i++) tick();
        chk("rst_mid_no_done", 64'(done_cnt), 64'(snap));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
